// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache with a single-outstanding
// refill controller and hit/miss performance counters.
module icache_fetch_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic [31:0]      pc_addr,
    input  logic             inv_all,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             if_stall,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t state, state_nx;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Only the word address of the missing fetch is kept.
    logic [29:0] miss_word;

    logic [INDEX_BITS-1:0] pc_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_W-1:0]      miss_tag;

    logic lookup_hit;
    logic hit_ev;
    logic miss_ev;
    logic fill;
    logic unused_low;

    assign pc_idx     = pc_addr[INDEX_BITS+1:2];
    assign pc_tag     = pc_addr[31:INDEX_BITS+2];
    assign miss_idx   = miss_word[INDEX_BITS-1:0];
    assign miss_tag   = miss_word[29:INDEX_BITS];
    assign unused_low = ^pc_addr[1:0];

    assign lookup_hit = valid_q[pc_idx] &&
                        (tag_q[pc_idx] == pc_tag);

    assign instr    = data_q[pc_idx];
    assign mem_addr = {miss_word, 2'b00};

    always_comb begin
        state_nx    = state;
        instr_valid = 1'b0;
        if_stall    = 1'b0;
        mem_req     = 1'b0;
        hit_ev      = 1'b0;
        miss_ev     = 1'b0;
        fill        = 1'b0;
        unique case (state)
            IDLE: begin
                if (fetch_en) begin
                    if (lookup_hit) begin
                        instr_valid = 1'b1;
                        hit_ev      = 1'b1;
                    end else begin
                        if_stall = 1'b1;
                        miss_ev  = 1'b1;
                        state_nx = MISS;
                    end
                end
            end
            MISS: begin
                mem_req  = 1'b1;
                if_stall = 1'b1;
                if (mem_ready) begin
                    fill     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid_q   <= '0;
            miss_word <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (hit_ev) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (miss_ev) begin
                miss_cnt  <= miss_cnt + CNT_W'(1);
                miss_word <= pc_addr[31:2];
            end
            if (fill) begin
                valid_q[miss_idx] <= 1'b1;
            end
            // A same-cycle invalidate wins over the fill's valid set.
            if (inv_all) begin
                valid_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= mem_rdata;
        end
    end

endmodule
